// File: rtl/dual_rail_mod_counter.sv
// Dual-rail token counter: counts tokens of one polarity modulo MOD under a
// four-phase return-to-zero handshake and answers each token with a dual-rail parity.
module dual_rail_mod_counter #(
    parameter int MOD         = 2,
    parameter int COUNT_ONES  = 0,
    parameter int SYNC_STAGES = 0,
    parameter int CW          = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bit0,
    input  logic          bit1,
    output logic          parity0,
    output logic          parity1,
    output logic [CW-1:0] count,
    output logic          err
);

    typedef enum logic [1:0] {WAIT_NULL, IDLE, ACK, ERR} state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MOD - 1);
    localparam logic          CNT_POL = (COUNT_ONES != 0);

    logic b0s, b1s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign b0s = bit0;
            assign b1s = bit1;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync0_q, sync0_d;
            logic [SYNC_STAGES-1:0] sync1_q, sync1_d;

            always_comb begin
                sync0_d    = '0;
                sync1_d    = '0;
                sync0_d[0] = bit0;
                sync1_d[0] = bit1;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync0_d[i] = sync0_q[i-1];
                    sync1_d[i] = sync1_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync0_q <= '0;
                    sync1_q <= '0;
                end else begin
                    sync0_q <= sync0_d;
                    sync1_q <= sync1_d;
                end
            end

            assign b0s = sync0_q[SYNC_STAGES-1];
            assign b1s = sync1_q[SYNC_STAGES-1];
        end
    endgenerate

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tok_q, tok_d;    // rail of the token held in ACK (1 = bit1)

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_NULL;
            cnt_q   <= '0;
            tok_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tok_q   <= tok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tok_d   = tok_q;
        case (state_q)
            WAIT_NULL: begin
                if (!b0s && !b1s) state_d = IDLE;
            end
            IDLE: begin
                if (b0s && b1s) begin
                    state_d = ERR;
                end else if (b0s ^ b1s) begin
                    state_d = ACK;
                    tok_d   = b1s;
                    if (b1s == CNT_POL)
                        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
                end
            end
            ACK: begin
                // Holding the same token keeps ACK; a rail swap without spacer is a violation.
                if (!b0s && !b1s)
                    state_d = IDLE;
                else if ((b0s && b1s) || (b1s != tok_q))
                    state_d = ERR;
            end
            ERR:     state_d = ERR;
            default: state_d = WAIT_NULL;
        endcase
    end

    logic          parity0_q, parity0_d;
    logic          parity1_q, parity1_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        parity0_d = 1'b0;
        parity1_d = 1'b0;
        err_d     = (state_q == ERR);
        count_d   = cnt_q;
        if (state_q == ACK) begin
            parity1_d = (cnt_q == '0);
            parity0_d = !parity1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity0_q <= 1'b0;
            parity1_q <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            parity0_q <= parity0_d;
            parity1_q <= parity1_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    assign parity0 = parity0_q;
    assign parity1 = parity1_q;
    assign err     = err_q;
    assign count   = count_q;

endmodule

// File: tb/tb_dual_rail_mod_counter.sv
// Bench for dual_rail_mod_counter: three configurations share one input stream and
// are checked every cycle against a flag-based token model plus literal expectations.
`timescale 1ns/1ps
module tb_dual_rail_mod_counter;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic bit0  = 1'b0;
    logic bit1  = 1'b0;

    always #5 clk = ~clk;

    logic       a_p0, a_p1, a_err;
    logic [0:0] a_cnt;
    logic       b_p0, b_p1, b_err;
    logic [1:0] b_cnt;
    logic       c_p0, c_p1, c_err;
    logic [2:0] c_cnt;

    dual_rail_mod_counter #(.MOD(2), .COUNT_ONES(0), .SYNC_STAGES(0)) dut_a (
        .clk(clk), .reset(reset), .bit0(bit0), .bit1(bit1),
        .parity0(a_p0), .parity1(a_p1), .count(a_cnt), .err(a_err));

    dual_rail_mod_counter #(.MOD(3), .COUNT_ONES(1), .SYNC_STAGES(0)) dut_b (
        .clk(clk), .reset(reset), .bit0(bit0), .bit1(bit1),
        .parity0(b_p0), .parity1(b_p1), .count(b_cnt), .err(b_err));

    dual_rail_mod_counter #(.MOD(5), .COUNT_ONES(0), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .reset(reset), .bit0(bit0), .bit1(bit1),
        .parity0(c_p0), .parity1(c_p1), .count(c_cnt), .err(c_err));

    logic act_p0 [N];
    logic act_p1 [N];
    logic act_err[N];
    int   act_cnt[N];
    assign act_p0[0] = a_p0;  assign act_p1[0] = a_p1;  assign act_err[0] = a_err;  assign act_cnt[0] = int'(a_cnt);
    assign act_p0[1] = b_p0;  assign act_p1[1] = b_p1;  assign act_err[1] = b_err;  assign act_cnt[1] = int'(b_cnt);
    assign act_p0[2] = c_p0;  assign act_p1[2] = c_p1;  assign act_err[2] = c_err;  assign act_cnt[2] = int'(c_cnt);

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int mod_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 5;
    endfunction
    function automatic bit pol_of(input int i);
        return (i == 1);
    endfunction
    function automatic int lag_of(input int i);
        return (i == 2) ? 2 : 0;
    endfunction

    // Token-level model: armed = a null has been seen since reset, busy = a token is held.
    bit         m_armed[N], m_busy[N], m_tok[N], m_err[N];
    int         m_cnt[N];
    logic [1:0] m_line[N][4];
    bit         e_p0[N], e_p1[N], e_err[N];
    int         e_cnt[N];

    task automatic step(input int i, input logic [1:0] v);
        if (m_err[i]) return;
        if (!m_armed[i]) begin
            if (v == 2'b00) m_armed[i] = 1'b1;
        end else if (!m_busy[i]) begin
            if (v == 2'b11) begin
                m_err[i] = 1'b1;
            end else if (v != 2'b00) begin
                m_busy[i] = 1'b1;
                m_tok[i]  = v[1];
                if (v[1] == pol_of(i)) m_cnt[i] = (m_cnt[i] + 1) % mod_of(i);
            end
        end else begin
            if (v == 2'b00)
                m_busy[i] = 1'b0;
            else if (v == 2'b11 || v[1] != m_tok[i])
                m_err[i] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        logic [1:0] v;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_armed[i] = 1'b0; m_busy[i] = 1'b0; m_tok[i] = 1'b0; m_err[i] = 1'b0;
                m_cnt[i] = 0;
                for (int k = 0; k < 4; k++) m_line[i][k] = 2'b00;
                e_p0[i] = 1'b0; e_p1[i] = 1'b0; e_err[i] = 1'b0; e_cnt[i] = 0;
            end else begin
                e_p1[i]  = m_busy[i] && !m_err[i] && (m_cnt[i] == 0);
                e_p0[i]  = m_busy[i] && !m_err[i] && (m_cnt[i] != 0);
                e_err[i] = m_err[i];
                e_cnt[i] = m_cnt[i];
                v = (lag_of(i) == 0) ? {bit1, bit0} : m_line[i][lag_of(i)-1];
                for (int k = 3; k > 0; k--) m_line[i][k] = m_line[i][k-1];
                m_line[i][0] = {bit1, bit0};
                step(i, v);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("inst%0d.parity0", i), int'(act_p0[i]),  int'(e_p0[i]));
                chk($sformatf("inst%0d.parity1", i), int'(act_p1[i]),  int'(e_p1[i]));
                chk($sformatf("inst%0d.err", i),     int'(act_err[i]), int'(e_err[i]));
                chk($sformatf("inst%0d.count", i),   act_cnt[i],       e_cnt[i]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic b0, input logic b1);
        bit0 = b0;
        bit1 = b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0);
        cyc(2);
        reset = 1'b0;
        cyc(4);
    endtask

    int tok_seq   [4];
    int a_cnt_exp [4];
    int a_p1_exp  [4];
    int b_cnt_exp [4];
    int b_p1_exp  [4];

    initial begin
        int r;
        bit v;
        cyc(2);
        chk_en = 1'b1;
        chk("reset.parity0", int'(a_p0), 0);
        chk("reset.parity1", int'(a_p1), 0);
        chk("reset.count",   int'(a_cnt), 0);
        chk("reset.err",     int'(a_err), 0);
        do_reset();

        // Tokens 0,1,0,0: even-zeroes on A, ones mod 3 on B.
        tok_seq   = '{0, 1, 0, 0};
        a_cnt_exp = '{1, 1, 0, 1};
        a_p1_exp  = '{0, 0, 1, 0};
        b_cnt_exp = '{0, 1, 1, 1};
        b_p1_exp  = '{1, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            drive(tok_seq[k] == 0, tok_seq[k] == 1);
            cyc(3);
            chk($sformatf("seq1.A.count[%0d]", k),   int'(a_cnt), a_cnt_exp[k]);
            chk($sformatf("seq1.A.parity1[%0d]", k), int'(a_p1),  a_p1_exp[k]);
            chk($sformatf("seq1.A.err[%0d]", k),     int'(a_err), 0);
            chk($sformatf("seq1.B.count[%0d]", k),   int'(b_cnt), b_cnt_exp[k]);
            chk($sformatf("seq1.B.parity1[%0d]", k), int'(b_p1),  b_p1_exp[k]);
            drive(1'b0, 1'b0);
            cyc(4);
        end

        // Tokens 1,1,1,1: B wraps from 2 to 0.
        do_reset();
        b_cnt_exp = '{1, 2, 0, 1};
        b_p1_exp  = '{0, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1);
            cyc(3);
            chk($sformatf("seq2.B.count[%0d]", k),   int'(b_cnt), b_cnt_exp[k]);
            chk($sformatf("seq2.B.parity1[%0d]", k), int'(b_p1),  b_p1_exp[k]);
            chk($sformatf("seq2.A.parity1[%0d]", k), int'(a_p1),  1);
            drive(1'b0, 1'b0);
            cyc(4);
        end

        // Two synchroniser stages on C: three-cycle latency both ways.
        do_reset();
        drive(1'b1, 1'b0);
        cyc(3);
        chk("sync.C.parity0_early", int'(c_p0), 0);
        cyc(1);
        chk("sync.C.parity0_rise", int'(c_p0), 1);
        chk("sync.C.count", int'(c_cnt), 1);
        cyc(2);
        drive(1'b0, 1'b0);
        cyc(3);
        chk("sync.C.parity0_hold", int'(c_p0), 1);
        cyc(1);
        chk("sync.C.parity0_null", int'(c_p0), 0);
        cyc(2);

        // Both rails high in IDLE.
        do_reset();
        drive(1'b1, 1'b1);
        cyc(2);
        chk("idle11.err", int'(a_err), 1);
        chk("idle11.parity0", int'(a_p0), 0);
        chk("idle11.parity1", int'(a_p1), 0);
        chk("idle11.count", int'(a_cnt), 0);
        drive(1'b0, 1'b0);
        cyc(2);
        drive(1'b1, 1'b0);
        cyc(3);
        chk("idle11.err_sticky", int'(a_err), 1);
        chk("idle11.count_frozen", int'(a_cnt), 0);
        chk("idle11.parity0_ignored", int'(a_p0), 0);
        drive(1'b0, 1'b0);
        cyc(2);

        // Rail swap in ACK without a spacer.
        do_reset();
        drive(1'b1, 1'b0);
        cyc(3);
        chk("swap.parity0_before", int'(a_p0), 1);
        chk("swap.count_before", int'(a_cnt), 1);
        drive(1'b0, 1'b1);
        cyc(2);
        chk("swap.err", int'(a_err), 1);
        chk("swap.parity0", int'(a_p0), 0);
        chk("swap.parity1", int'(a_p1), 0);
        chk("swap.count", int'(a_cnt), 1);
        drive(1'b0, 1'b0);
        cyc(2);

        // Reset in ACK with the token still held.
        do_reset();
        drive(1'b1, 1'b0);
        cyc(3);
        chk("rstack.count_before", int'(a_cnt), 1);
        reset = 1'b1;
        cyc(2);
        chk("rstack.count", int'(a_cnt), 0);
        chk("rstack.parity0", int'(a_p0), 0);
        chk("rstack.err", int'(a_err), 0);
        reset = 1'b0;
        cyc(3);
        chk("rstack.held_count", int'(a_cnt), 0);
        chk("rstack.held_parity0", int'(a_p0), 0);
        chk("rstack.held_parity1", int'(a_p1), 0);
        drive(1'b0, 1'b0);
        cyc(3);
        drive(1'b1, 1'b0);
        cyc(3);
        chk("rstack.recount", int'(a_cnt), 1);
        chk("rstack.reparity0", int'(a_p0), 1);
        drive(1'b0, 1'b0);
        cyc(3);

        // Randomised traffic: mostly clean handshakes with violations and resets mixed in.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            v = 1'($urandom_range(0, 1));
            if (r < 75) begin
                drive(!v, v);
                cyc($urandom_range(1, 6));
                drive(1'b0, 1'b0);
                cyc($urandom_range(1, 6));
            end else if (r < 85) begin
                drive(!v, v);
                cyc($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 0) drive(v, !v);
                else drive(1'b1, 1'b1);
                cyc(2);
                drive(1'b0, 1'b0);
                cyc(2);
                if ($urandom_range(0, 1) == 0) do_reset();
            end else if (r < 93) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                reset = 1'b1;
                cyc($urandom_range(1, 2));
                reset = 1'b0;
                cyc($urandom_range(1, 3));
                drive(1'b0, 1'b0);
                cyc(2);
            end else begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                cyc($urandom_range(1, 4));
            end
        end

        drive(1'b0, 1'b0);
        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_rail_mod_counter.md
Name: dual_rail_mod_counter

Overview:
Clocked, parametrised successor to the dual-rail even-zeroes checker. It accepts a stream of dual-rail bit tokens (bit0/bit1) under a four-phase return-to-zero handshake. It counts the tokens of a selected polarity modulo MOD and answers each token with a dual-rail result: parity1 when the updated count is 0 mod MOD, parity0 otherwise. It adds a configurable input synchroniser, a visible count, and sticky protocol-error detection. The block sits between a dual-rail producer and synchronous consumer logic.

Parameters:
MOD, 2, modulus of the token count; legal range is MOD >= 2. MOD=2 gives even-zeroes behaviour.
COUNT_ONES, 0, selects counted polarity: 0 counts bit0 tokens (zeroes), 1 counts bit1 tokens (ones).
SYNC_STAGES, 0, number of flop stages on bit0/bit1 before the FSM; legal range 0..3.
CW, $clog2(MOD), width of count. Derived; do not override.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
bit0  input  1  dual-rail data, false rail (token value 0)
bit1  input  1  dual-rail data, true rail (token value 1)
parity0  output  1  dual-rail result, false rail: updated count != 0
parity1  output  1  dual-rail result, true rail: updated count == 0
count  output  CW  current count modulo MOD
err  output  1  sticky protocol-violation flag

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Synchroniser: bit0/bit1 pass through SYNC_STAGES flops. Let b0s/b1s be the synchronised values. Every latency figure below adds SYNC_STAGES cycles. Reset clears the synchroniser flops to 0.
- Reset values: parity0=0, parity1=0, count=0, err=0, state=WAIT_NULL.
- FSM states:
  - WAIT_NULL: outputs null. Moves to IDLE on the first sampled b0s=0 and b1s=0. This prevents a token still held across reset from being counted.
  - IDLE: outputs null.
    - b0s xor b1s: token accepted. Next cycle: count updated, exactly one parity rail set, state ACK.
    - Both high: go to ERR.
    - Both low: stay in IDLE.
  - ACK: parity rail held; count stable.
    - Both low (spacer): next cycle both parity rails = 0, state IDLE.
    - Both high: go to ERR.
    - Input still equals the accepted token: hold.
    - Input switched to the opposite rail with no spacer: go to ERR.
  - ERR: err=1, parity0=parity1=0, count frozen, all inputs ignored. Leaves only on reset.
- Count update on an accepted token:
  - Counted polarity (bit0 if COUNT_ONES=0, else bit1): count = (count==MOD-1) ? 0 : count+1.
  - Other polarity: count unchanged.
- Result on every accepted token, counted or not: parity1 = (updated count == 0), parity0 = !parity1. Exactly one rail is high in ACK.
- Latency (SYNC_STAGES=0): data sampled at edge t gives parity valid after edge t+1. Spacer sampled at edge u gives parity null after edge u+1.
- Throughput: at most one token per 4 cycles (data, ack, spacer, null).
- Reset mid-handshake: outputs null, count=0, err=0, state WAIT_NULL. The in-flight token is discarded and not counted.
- Never: parity0 and parity1 high together; count >= MOD; parity changing while in ACK.

Test Plan:
1. MOD=2, COUNT_ONES=0: tokens 0,1,0,0 with full handshake each. Required parity1 sequence per token is 0,0,1,0; count goes 1,1,0,1; err stays 0.
2. MOD=3, COUNT_ONES=1: tokens 1,1,1,1. Required parity1 is 0,0,1,0 and count goes 1,2,0,1. Shows wrap from MOD-1 to 0.
3. SYNC_STAGES=2: a single bit0 token sampled at edge t. Required parity0 rises after edge t+3, and null returns 3 cycles after the spacer is driven.
4. bit0=bit1=1 driven in IDLE. Required: err=1 on the next cycle, parity rails 0, count frozen, and a later valid token is ignored until reset.
5. In ACK, drop bit0 and raise bit1 on the same edge (no spacer). Required: err=1, parity rails go null, count unchanged.
6. Assert reset while in ACK with bit0 still high. Required: outputs null and count=0. After reset deasserts with bit0 still high, no token is counted; the block counts again only after a spacer is seen.
